tb_stream_checker: RTL and testbench
====================================

// Module: tb_stream_checker
// PURPOSE
//  Receive-side checker for the testbench stimulus/control harness. Consumes the data stream a
//  stimulus generator drives under random stall/valid_off gating. Compares each accepted word
//  against an internal LFSR reference model and counts words and mismatches. Raises stop_sim
//  on completion, error limit or timeout.
// PARAMETERS
//  DW       32          data width, 1..32; expected word = LFSR[DW-1:0]
//  SEED     32'hACE1    LFSR reset/restart value, must be nonzero
//  NUM_WORDS 16'd256    words to accept before DONE, >=1
//  MAX_ERR  8'd4        mismatch count that forces FAIL, >=1
//  TIMEOUT  16'd1000    consecutive RUN cycles without a transfer that force FAIL
// PORTS
//  clk        in   1    clock
//  reset_     in   1    reset, asynchronous, active-low
//  cmp_on     in   1    compare enable; 0->1 edge while IDLE starts a run
//  stall      in   1    backpressure from control block; no transfer while 1
//  valid_in   in   1    upstream word valid
//  data_in    in   DW   upstream word
//  ready_out  out  1    = (state==RUN) & ~stall, combinational
//  mismatch   out  1    1-cycle pulse, cycle after a failing compare
//  rx_cnt     out  16   accepted words
//  err_cnt    out  8    mismatches, saturates at 8'hFF
//  stop_sim   out  1    sticky end-of-test flag
//  pass       out  1    stop_sim & DONE & err_cnt==0
// BEHAVIOUR
//  - Reset (reset_ low, any time incl. mid-run): state=IDLE, lfsr=SEED, rx_cnt=0, err_cnt=0,
//    mismatch=0, stop_sim=0, pass=0, idle timer=0. Registers only; no state survives reset.
//  - Transfer: acc = valid_in & ready_out. Sampled on the same posedge clk; no skid buffer.
//  - Compare on acc: data_in vs lfsr[DW-1:0]. Inequality sets mismatch=1 on the next cycle and
//    increments err_cnt. Every acc increments rx_cnt and advances the LFSR one step.
//  - LFSR: 32-bit Galois, right shift, poly 32'h80200003.
//    next = {1'b0,l[31:1]} ^ (l[0] ? 32'h80200003 : 0).
//  - FSM:
//    IDLE: ready_out=0. Rising cmp_on (registered copy was 0, now 1) -> RUN. Entering RUN
//      reloads lfsr=SEED and clears rx_cnt, err_cnt and the timer.
//    RUN: on acc with rx_cnt==NUM_WORDS-1 -> DONE; the final word is still compared and counted.
//      err_cnt reaching MAX_ERR -> FAIL. FAIL takes priority when both occur on the same word.
//      Timer counts cycles with no acc and clears on acc; timer==TIMEOUT-1 without acc -> FAIL.
//      cmp_on low while in RUN -> PAUSE.
//    PAUSE: ready_out=0. Timer frozen. lfsr and counters held. cmp_on high -> RUN with no reload.
//    DONE / FAIL: ready_out=0. stop_sim=1 from the first cycle in the state. Terminal until reset.
//  - Stall and the valid/ready handshake are independent. A stall of any length is legal.
//    Stall cycles count toward the timeout.
//  - err_cnt saturates at 8'hFF. rx_cnt does not wrap because DONE stops acceptance.
//  - pass asserts together with stop_sim only in DONE with err_cnt==0, and is held.
//  - Simultaneous cmp_on fall and a final acc: the acc wins -> DONE.
// TESTING
//  1 Reset, cmp_on 0->1, 256 correct LFSR words, stall=0
//    -> rx_cnt=256, err_cnt=0, stop_sim=1 and pass=1 one cycle after word 256.
//  2 Same stream with random stall/valid gaps
//    -> no word accepted while stall=1; final rx_cnt=256, pass=1.
//  3 Corrupt words 10,20,30,40 (bit0 flipped)
//    -> 4 mismatch pulses, err_cnt=4, FAIL after word 40, stop_sim=1, pass=0, rx_cnt=40.
//  4 After 5 words hold valid_in=0 for 1000 cycles
//    -> FAIL at idle cycle 1000, rx_cnt=5, pass=0.
//  5 cmp_on low for 50 cycles after word 100, then high
//    -> no timeout; word 101 compared against LFSR step 101; run completes with pass=1.
//  6 reset_ low for 1 cycle mid-run at word 77
//    -> all outputs return to reset values asynchronously; next cmp_on edge restarts from SEED.

Source files
------------

// File: rtl/tb_stream_checker.sv
// Receive-side stream checker: compares each accepted word against a 32-bit
// Galois LFSR reference, counts words and mismatches, and raises stop_sim on
// completion, error limit or idle timeout.
module tb_stream_checker #(
  parameter int          DW        = 32,
  parameter logic [31:0] SEED      = 32'hACE1,
  parameter logic [15:0] NUM_WORDS = 16'd256,
  parameter logic [7:0]  MAX_ERR   = 8'd4,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          cmp_on,
  input  logic          stall,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  output logic          ready_out,
  output logic          mismatch,
  output logic [15:0]   rx_cnt,
  output logic [7:0]    err_cnt,
  output logic          stop_sim,
  output logic          pass
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE,
    FAIL
  } state_t;

  state_t      state;
  logic [31:0] lfsr;
  logic [15:0] timer;
  logic        cmp_on_q;

  logic        acc;
  logic        word_bad;
  logic [7:0]  err_inc;
  logic        final_word;
  logic        err_limit;
  logic        idle_expired;

  // One step of the right-shifting Galois LFSR, polynomial 32'h80200003.
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    lfsr_next = {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Handshake, compare result and the transition conditions used by the FSM.
  always_comb begin
    ready_out    = (state == RUN) & ~stall;
    acc          = valid_in & ready_out;
    word_bad     = (data_in != lfsr[DW-1:0]);
    err_inc      = (word_bad && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    final_word   = (rx_cnt == NUM_WORDS - 16'd1);
    err_limit    = (err_inc >= MAX_ERR);
    idle_expired = (timer == TIMEOUT - 16'd1);
  end

  // Run-control FSM with registered counters and status flags.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      lfsr     <= SEED;
      rx_cnt   <= '0;
      err_cnt  <= '0;
      timer    <= '0;
      cmp_on_q <= 1'b0;
      mismatch <= 1'b0;
      stop_sim <= 1'b0;
      pass     <= 1'b0;
    end else begin
      cmp_on_q <= cmp_on;
      mismatch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmp_on && !cmp_on_q) begin
            state   <= RUN;
            lfsr    <= SEED;
            rx_cnt  <= '0;
            err_cnt <= '0;
            timer   <= '0;
          end
        end
        RUN: begin
          if (acc) begin
            // The accepted word is always scored, even when it ends the run
            // or coincides with cmp_on falling.
            mismatch <= word_bad;
            err_cnt  <= err_inc;
            rx_cnt   <= rx_cnt + 16'd1;
            lfsr     <= lfsr_next(lfsr);
            timer    <= '0;
            if (err_limit) begin
              state    <= FAIL;
              stop_sim <= 1'b1;
            end else if (final_word) begin
              state    <= DONE;
              stop_sim <= 1'b1;
              pass     <= (err_inc == 8'd0);
            end else if (!cmp_on) begin
              state <= PAUSE;
            end
          end else if (idle_expired) begin
            state    <= FAIL;
            stop_sim <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
            if (!cmp_on) begin
              state <= PAUSE;
            end
          end
        end
        PAUSE: begin
          if (cmp_on) begin
            state <= RUN;
          end
        end
        DONE, FAIL: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tb_stream_checker.sv
// Self-checking bench for tb_stream_checker: randomized and directed streams
// scored against a word-index reference model.
module tb_tb_stream_checker;

  localparam int          DW        = 32;
  localparam logic [31:0] SEED      = 32'hACE1;
  localparam int          NUM_WORDS = 256;
  localparam int          MAX_ERR   = 4;
  localparam int          TIMEOUT   = 1000;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_DONE  = 3;
  localparam int P_FAIL  = 4;

  logic          clk;
  logic          reset_;
  logic          cmp_on;
  logic          stall;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          mismatch;
  logic [15:0]   rx_cnt;
  logic [7:0]    err_cnt;
  logic          stop_sim;
  logic          pass;

  tb_stream_checker #(
    .DW       (DW),
    .SEED     (SEED),
    .NUM_WORDS(16'd256),
    .MAX_ERR  (8'd4),
    .TIMEOUT  (16'd1000)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .cmp_on   (cmp_on),
    .stall    (stall),
    .valid_in (valid_in),
    .data_in  (data_in),
    .ready_out(ready_out),
    .mismatch (mismatch),
    .rx_cnt   (rx_cnt),
    .err_cnt  (err_cnt),
    .stop_sim (stop_sim),
    .pass     (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Expected word k is the seed advanced k steps.
  logic [31:0] exp_words [NUM_WORDS];

  int m_phase;
  int m_rx;
  int m_err;
  int m_timer;
  bit m_cq;
  bit m_mm;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_rx    = 0;
    m_err   = 0;
    m_timer = 0;
    m_cq    = 0;
    m_mm    = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic c);
    valid_in = v;
    data_in  = d;
    stall    = s;
    cmp_on   = c;
    #1;
  endtask

  task automatic tick();
    bit acc;
    bit bad;
    @(posedge clk);
    acc  = (m_phase == P_RUN) && !stall && valid_in;
    m_mm = 0;
    case (m_phase)
      P_IDLE: if (cmp_on && !m_cq) begin
        m_phase = P_RUN; m_rx = 0; m_err = 0; m_timer = 0;
      end
      P_RUN: begin
        if (acc) begin
          bad  = (data_in != exp_words[m_rx]);
          m_mm = bad;
          if (bad && m_err < 255) m_err++;
          m_rx++;
          m_timer = 0;
          if (m_err >= MAX_ERR) m_phase = P_FAIL;
          else if (m_rx == NUM_WORDS) m_phase = P_DONE;
          else if (!cmp_on) m_phase = P_PAUSE;
        end else if (m_timer == TIMEOUT - 1) begin
          m_phase = P_FAIL;
        end else begin
          m_timer++;
          if (!cmp_on) m_phase = P_PAUSE;
        end
      end
      P_PAUSE: if (cmp_on) m_phase = P_RUN;
      default: ;
    endcase
    m_cq = cmp_on;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic start_run();
    drive(0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    tick();
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++; if (rx_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_rx_cnt: got %0d, expected 0", rx_cnt); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d, expected 0", err_cnt); end
    vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL reset_mismatch: got %b, expected 0", mismatch); end
    vectors++; if (stop_sim !== 1'b0) begin miscompares++; $display("FAIL reset_stop_sim: got %b, expected 0", stop_sim); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b, expected 0", pass); end
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0", ready_out); end
    reset_ = 1'b1;
    drive(1, 0, 0, 0);
    tick();
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL idle_ready: got %b, expected 0", ready_out); end
    vectors++; if (rx_cnt !== 16'd0) begin miscompares++; $display("FAIL idle_rx_cnt: got %0d, expected 0", rx_cnt); end
  endtask

  task automatic test_clean_run();
    do_reset();
    start_run();
    drive(0, 0, 0, 1);
    vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("FAIL run_ready: got %b, expected 1", ready_out); end
    for (int i = 0; i < NUM_WORDS; i++) begin
      drive(1, exp_words[i], 0, 1);
      tick();
      if (i == NUM_WORDS - 2) begin
        vectors++; if (stop_sim !== 1'b0) begin miscompares++; $display("FAIL clean_early_stop: got %b, expected 0", stop_sim); end
      end
    end
    drive(0, 0, 0, 1);
    vectors++; if (rx_cnt !== 16'd256) begin miscompares++; $display("FAIL clean_rx_cnt: got %0d, expected 256", rx_cnt); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL clean_err_cnt: got %0d, expected 0", err_cnt); end
    vectors++; if (stop_sim !== 1'b1) begin miscompares++; $display("FAIL clean_stop_sim: got %b, expected 1", stop_sim); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL clean_pass: got %b, expected 1", pass); end
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL clean_done_ready: got %b, expected 0", ready_out); end
  endtask

  task automatic test_random_gaps();
    int  cycles;
    int  bench_cnt;
    logic s;
    logic v;
    do_reset();
    start_run();
    cycles    = 0;
    bench_cnt = 0;
    while (m_phase == P_RUN && cycles < 5000) begin
      s = ($urandom_range(0, 2) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(v, exp_words[m_rx], s, 1);
      vectors++; if (ready_out !== !s) begin miscompares++; $display("FAIL gaps_ready: got %b, expected %b", ready_out, !s); end
      if (v && !s) bench_cnt++;
      tick();
      vectors++; if (rx_cnt !== 16'(bench_cnt)) begin miscompares++; $display("FAIL gaps_rx_cnt: got %0d, expected %0d", rx_cnt, bench_cnt); end
      cycles++;
    end
    vectors++; if (rx_cnt !== 16'd256) begin miscompares++; $display("FAIL gaps_final_rx: got %0d, expected 256", rx_cnt); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL gaps_pass: got %b, expected 1", pass); end
    vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL gaps_err_cnt: got %0d, expected 0", err_cnt); end
  endtask

  task automatic test_corrupt();
    int pulses;
    int budget;
    logic [31:0] d;
    do_reset();
    start_run();
    pulses = 0;
    budget = 0;
    while (m_phase == P_RUN && budget < 100) begin
      d = exp_words[m_rx];
      if (((m_rx + 1) % 10 == 0) && (m_rx + 1 <= 40)) d[0] = ~d[0];
      drive(1, d, 0, 1);
      tick();
      vectors++; if (mismatch !== m_mm) begin miscompares++; $display("FAIL corrupt_mismatch: got %b, expected %b at word %0d", mismatch, m_mm, m_rx); end
      if (mismatch === 1'b1) pulses++;
      budget++;
    end
    vectors++; if (pulses != 4) begin miscompares++; $display("FAIL corrupt_pulses: got %0d, expected 4", pulses); end
    vectors++; if (err_cnt !== 8'd4) begin miscompares++; $display("FAIL corrupt_err_cnt: got %0d, expected 4", err_cnt); end
    vectors++; if (rx_cnt !== 16'd40) begin miscompares++; $display("FAIL corrupt_rx_cnt: got %0d, expected 40", rx_cnt); end
    vectors++; if (stop_sim !== 1'b1) begin miscompares++; $display("FAIL corrupt_stop_sim: got %b, expected 1", stop_sim); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL corrupt_pass: got %b, expected 0", pass); end
    for (int k = 0; k < 5; k++) begin
      drive(1, exp_words[40 + k], 0, 1);
      vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL fail_ready: got %b, expected 0", ready_out); end
      tick();
    end
    vectors++; if (rx_cnt !== 16'd40) begin miscompares++; $display("FAIL fail_hold_rx: got %0d, expected 40", rx_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) begin
      drive(1, exp_words[i], 0, 1);
      tick();
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      drive(0, 0, 0, 1);
      tick();
      if (k == TIMEOUT - 1) begin
        vectors++; if (stop_sim !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b, expected 0", stop_sim); end
      end
    end
    vectors++; if (stop_sim !== 1'b1) begin miscompares++; $display("FAIL timeout_stop: got %b, expected 1", stop_sim); end
    vectors++; if (rx_cnt !== 16'd5) begin miscompares++; $display("FAIL timeout_rx_cnt: got %0d, expected 5", rx_cnt); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL timeout_pass: got %b, expected 0", pass); end
  endtask

  task automatic test_pause();
    int budget;
    do_reset();
    start_run();
    for (int i = 0; i < 100; i++) begin
      drive(1, exp_words[i], 0, 1);
      tick();
    end
    for (int k = 0; k < 50; k++) begin
      drive(0, 0, 0, 0);
      if (k >= 1) begin
        vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL pause_ready: got %b, expected 0", ready_out); end
      end
      tick();
    end
    vectors++; if (rx_cnt !== 16'd100) begin miscompares++; $display("FAIL pause_rx_cnt: got %0d, expected 100", rx_cnt); end
    vectors++; if (stop_sim !== 1'b0) begin miscompares++; $display("FAIL pause_stop: got %b, expected 0", stop_sim); end
    budget = 0;
    while (m_phase != P_DONE && m_phase != P_FAIL && budget < 400) begin
      drive(1, exp_words[m_rx], 0, 1);
      tick();
      if (m_rx == 101) begin
        vectors++; if (err_cnt !== 8'd0) begin miscompares++; $display("FAIL pause_word101: got err_cnt %0d, expected 0", err_cnt); end
      end
      budget++;
    end
    vectors++; if (rx_cnt !== 16'd256) begin miscompares++; $display("FAIL pause_final_rx: got %0d, expected 256", rx_cnt); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL pause_pass: got %b, expected 1", pass); end
  endtask

  task automatic test_midrun_reset();
    int budget;
    do_reset();
    start_run();
    for (int i = 0; i < 77; i++) begin
      drive(1, exp_words[i], 0, 1);
      tick();
    end
    vectors++; if (rx_cnt !== 16'd77) begin miscompares++; $display("FAIL mid_rx_before: got %0d, expected 77", rx_cnt); end
    #2;
    reset_ = 1'b0;
    #1;
    vectors++; if (rx_cnt !== 16'd0) begin miscompares++; $display("FAIL async_rx_cnt: got %0d, expected 0", rx_cnt); end
    vectors++; if (ready_out !== 1'b0) begin miscompares++; $display("FAIL async_ready: got %b, expected 0", ready_out); end
    vectors++; if (stop_sim !== 1'b0 || pass !== 1'b0 || err_cnt !== 8'd0) begin
      miscompares++; $display("FAIL async_flags: got stop %b pass %b err %0d, expected 0 0 0", stop_sim, pass, err_cnt);
    end
    model_reset();
    drive(0, 0, 0, 0);
    @(negedge clk);
    reset_ = 1'b1;
    start_run();
    budget = 0;
    while (m_phase == P_RUN && budget < 400) begin
      drive(1, exp_words[m_rx], 0, 1);
      tick();
      if (m_rx == 1) begin
        vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL restart_first_word: got mismatch %b, expected 0", mismatch); end
      end
      budget++;
    end
    vectors++; if (rx_cnt !== 16'd256) begin miscompares++; $display("FAIL restart_rx_cnt: got %0d, expected 256", rx_cnt); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL restart_pass: got %b, expected 1", pass); end
  endtask

  initial begin
    logic [31:0] l;
    l = SEED;
    for (int i = 0; i < NUM_WORDS; i++) begin
      exp_words[i] = l;
      l = {1'b0, l[31:1]} ^ (l[0] ? 32'h80200003 : 32'h0);
    end
    reset_   = 1'b0;
    cmp_on   = 1'b0;
    stall    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();
    test_reset();
    test_clean_run();
    test_random_gaps();
    test_corrupt();
    test_timeout();
    test_pause();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
